// File: rtl/acorn128_pkg.sv
// Shared types and constants for the ACORN-128 frame loader.
// ACORN_LOADER_TAGCHK_EN adds an expected-tag field to decrypt frames and a match word to the response.
package acorn128_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLR   = 3'd2,
    ST_START = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam int FRAME_WORDS    = 17;
  localparam int FRAME_WORDS_TC = 21;
  localparam int RESP_WORDS     = 8;

  localparam logic [31:0] ERR_TIMEOUT_WORD = 32'hDEAD_0001;

  // Index of the final word of a frame; the header is word 0.
  localparam logic [4:0] LAST_WORD_IDX    = 5'(FRAME_WORDS - 1);
  localparam logic [4:0] LAST_WORD_IDX_TC = 5'(FRAME_WORDS_TC - 1);

`ifdef ACORN_LOADER_TAGCHK_EN
  localparam int SER_WORDS = RESP_WORDS + 1;
`else
  localparam int SER_WORDS = RESP_WORDS;
`endif

endpackage

// File: rtl/acorn128_frame_loader_if.sv
// Job-frame input stream and response output stream of the ACORN-128 frame loader.
interface acorn128_frame_loader_if;
  // Both streams: a word moves on a rising clock edge where valid & ready are both high;
  // the producer keeps data (and last) stable while valid is high and ready is low.
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/acorn128_blk_ser.sv
// Wide-to-32-bit shift-out serializer: loads a left-aligned block and a word count,
// emits MS word first with valid/ready handshake and flags the final word.
module acorn128_blk_ser #(
  parameter int WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WORDS*32-1:0]   load_data,
  input  logic [3:0]            load_words,
  input  logic                  m_ready,
  output logic [31:0]           m_data,
  output logic                  m_valid,
  output logic                  m_last,
  output logic                  done
);

  localparam int W = WORDS * 32;

  logic [W-1:0] sh_q, sh_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         xfer;

  assign xfer = (cnt_q != 4'd0) && m_ready;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = load_data;
      cnt_d = load_words;
    end else if (xfer) begin
      // Zero fill so m_data returns to 0 once the block has drained.
      sh_d  = {sh_q[W-33:0], 32'h0};
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign m_data  = sh_q[W-1 -: 32];
  assign m_valid = (cnt_q != 4'd0);
  assign m_last  = (cnt_q == 4'd1);
  assign done    = xfer && (cnt_q == 4'd1);

endmodule

// File: rtl/acorn128_frame_loader.sv
// Front end for acorn128_top: assembles one job frame into core operands, runs the core
// with a timeout, and streams result+tag back. ACORN_LOADER_TAGCHK_EN enables decrypt tag checking.
module acorn128_frame_loader
  import acorn128_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CLR_CYC     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  acorn128_frame_loader_if.slave  bus,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    core_rst,
  output logic                    core_start,
  output logic                    core_encrypt,
  output logic [127:0]            core_key,
  output logic [127:0]            core_iv,
  output logic [127:0]            core_ad,
  output logic [127:0]            core_pt,
  output logic [127:0]            core_ct,
  output logic [63:0]             core_len,
  input  logic [127:0]            core_result,
  input  logic [127:0]            core_tag,
  input  logic                    core_ready,
  output state_e                  dbg_state
);

  localparam int CW    = $clog2(TIMEOUT_CYC + CLR_CYC + 1);
  localparam int SER_W = SER_WORDS * 32;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [31:0]    hdr_q, hdr_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   iv_q, iv_d;
  logic [127:0]   ad_q, ad_d;
  logic [127:0]   data_q, data_d;
  logic           err_q, err_d;
  logic           s_ready_q, s_ready_d;
  logic           core_rst_q, core_rst_d;
  logic           core_start_q, core_start_d;
  logic           busy_q, busy_d;

  logic           s_xfer;
  logic [4:0]     last_idx;
  logic           ser_load;
  logic [SER_W-1:0] ser_data;
  logic [3:0]     ser_words;
  logic           ser_done;

`ifdef ACORN_LOADER_TAGCHK_EN
  logic [127:0]   etag_q, etag_d;
  logic           tag_match;
  assign tag_match = (core_tag == etag_q);
  assign last_idx  = hdr_q[31] ? LAST_WORD_IDX : LAST_WORD_IDX_TC;
`else
  assign last_idx  = LAST_WORD_IDX;
`endif

  assign s_xfer = bus.s_valid && s_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    hdr_d     = hdr_q;
    key_d     = key_q;
    iv_d      = iv_q;
    ad_d      = ad_q;
    data_d    = data_q;
    err_d     = err_q;
    ser_load  = 1'b0;
    ser_data  = '0;
    ser_words = 4'd0;
`ifdef ACORN_LOADER_TAGCHK_EN
    etag_d    = etag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (s_xfer) begin
          hdr_d   = bus.s_data;
          err_d   = 1'b0;
          cnt_d   = 5'd1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_xfer) begin
          // Words 1-4 key, 5-8 IV, 9-12 AD, 13-16 data, 17-20 expected tag.
          if (cnt_q <= 5'd4)       key_d  = {key_q[95:0], bus.s_data};
          else if (cnt_q <= 5'd8)  iv_d   = {iv_q[95:0], bus.s_data};
          else if (cnt_q <= 5'd12) ad_d   = {ad_q[95:0], bus.s_data};
          else if (cnt_q <= 5'd16) data_d = {data_q[95:0], bus.s_data};
`ifdef ACORN_LOADER_TAGCHK_EN
          else                     etag_d = {etag_q[95:0], bus.s_data};
`endif
          if (cnt_q == last_idx) begin
            cyc_d   = '0;
            state_d = ST_CLR;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_CLR: begin
        if (cyc_q == CLR_LAST) begin
          cyc_d   = '0;
          state_d = ST_START;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_START: begin
        if (core_ready) begin
          ser_load  = 1'b1;
`ifdef ACORN_LOADER_TAGCHK_EN
          if (hdr_q[31]) begin
            ser_data  = {core_result, core_tag, 32'h0};
            ser_words = 4'(RESP_WORDS);
          end else begin
            ser_data  = {core_result, core_tag, 31'h0, tag_match};
            ser_words = 4'(SER_WORDS);
          end
`else
          ser_data  = {core_result, core_tag};
          ser_words = 4'(RESP_WORDS);
`endif
          state_d = ST_DRAIN;
        end else if (cyc_q == TMO_LAST) begin
          err_d     = 1'b1;
          ser_load  = 1'b1;
          ser_data  = {ERR_TIMEOUT_WORD, {(SER_W-32){1'b0}}};
          ser_words = 4'd1;
          state_d   = ST_DRAIN;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (ser_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they align with the state flop.
    s_ready_d    = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    core_rst_d   = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_CLR);
    core_start_d = (state_d == ST_START);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cyc_q        <= '0;
      hdr_q        <= '0;
      key_q        <= '0;
      iv_q         <= '0;
      ad_q         <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      s_ready_q    <= 1'b1;
      core_rst_q   <= 1'b1;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      hdr_q        <= hdr_d;
      key_q        <= key_d;
      iv_q         <= iv_d;
      ad_q         <= ad_d;
      data_q       <= data_d;
      err_q        <= err_d;
      s_ready_q    <= s_ready_d;
      core_rst_q   <= core_rst_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
    end
  end

`ifdef ACORN_LOADER_TAGCHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) etag_q <= '0;
    else        etag_q <= etag_d;
  end
`endif

  acorn128_blk_ser #(.WORDS(SER_WORDS)) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ser_load),
    .load_data  (ser_data),
    .load_words (ser_words),
    .m_ready    (bus.m_ready),
    .m_data     (bus.m_data),
    .m_valid    (bus.m_valid),
    .m_last     (bus.m_last),
    .done       (ser_done)
  );

  assign bus.s_ready   = s_ready_q;
  assign busy          = busy_q;
  assign err_timeout   = err_q;
  assign core_rst      = core_rst_q;
  assign core_start    = core_start_q;
  assign core_encrypt  = hdr_q[31];
  assign core_len      = {33'b0, hdr_q[30:0]};
  assign core_key      = key_q;
  assign core_iv       = iv_q;
  assign core_ad       = ad_q;
  assign core_pt       = data_q;
  assign core_ct       = data_q;
  assign dbg_state     = state_q;

endmodule
